// File: rtl/matrix_add_arbiter.sv
// matrix_add_arbiter: round-robin sharing of one matrix_add engine among NUM_REQ requesters
module matrix_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_DIM = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*3-1:0]         req_rows,
  input  logic [NUM_REQ*3-1:0]         req_cols,
  output logic [NUM_REQ-1:0]           grant,
  output logic [$clog2(NUM_REQ)-1:0]   sel,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           err,
  output logic                         eng_start,
  output logic [2:0]                   eng_rows,
  output logic [2:0]                   eng_cols,
  input  logic                         eng_done,
  output logic                         busy
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RUN, RELEASE, RESP} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n, ack_n, err_n, ack_prev, elig;
  logic [SW-1:0] sel_n, rr_ptr, rr_n, win, idx;
  logic [2:0] rows_n, cols_n, win_rows, win_cols;
  logic [2:0] rows_a [NUM_REQ];
  logic [2:0] cols_a [NUM_REQ];
  logic [CW-1:0] cnt, cnt_n;
  logic start_n, busy_n, err_flag, errf_n, win_vld, dims_ok;
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    assign rows_a[k] = req_rows[3*k +: 3];
    assign cols_a[k] = req_cols[3*k +: 3];
  end
  // the requester acked last cycle may still hold req while it deasserts, so hide it for one cycle
  assign elig = req & ~ack_prev;
  assign win_rows = rows_a[win];
  assign win_cols = cols_a[win];
  assign dims_ok = (win_rows != 3'd0) && (win_rows <= 3'(MAX_DIM)) &&
                   (win_cols != 3'd0) && (win_cols <= 3'(MAX_DIM));
  // round-robin pick: scan downward in priority order so the nearest eligible bit from rr_ptr wins
  always_comb begin
    win_vld = 1'b0;
    win = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = SW'((int'(rr_ptr) + i) % NUM_REQ);
      if (elig[idx]) begin
        win_vld = 1'b1;
        win = idx;
      end
    end
  end
  // next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n = sel;
    rows_n = eng_rows;
    cols_n = eng_cols;
    start_n = eng_start;
    cnt_n = cnt;
    errf_n = err_flag;
    rr_n = rr_ptr;
    case (state)
      IDLE: if (win_vld) begin
        grant_n = NUM_REQ'(1) << win;
        sel_n = win;
        rows_n = win_rows;
        cols_n = win_cols;
        rr_n = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        start_n = dims_ok;
        cnt_n = '0;
        errf_n = !dims_ok;
        state_n = dims_ok ? RUN : RESP;
      end
      RUN: begin
        cnt_n = cnt + 1'b1;
        if (eng_done) begin
          start_n = 1'b0;
          state_n = RELEASE;
        end else if (cnt == CW'(TIMEOUT)) begin
          start_n = 1'b0;
          errf_n = 1'b1;
          state_n = RELEASE;
        end
      end
      RELEASE: state_n = eng_done ? RELEASE : RESP;
      default: begin
        grant_n = '0;
        errf_n = 1'b0;
        state_n = IDLE;
      end
    endcase
    ack_n = (state_n == RESP) ? grant_n : '0;
    err_n = (state_n == RESP && errf_n) ? grant_n : '0;
    busy_n = state_n != IDLE;
  end
  // state and output registers, cleared asynchronously so eng_start drops the instant reset asserts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      sel <= '0;
      ack <= '0;
      err <= '0;
      eng_start <= 1'b0;
      eng_rows <= '0;
      eng_cols <= '0;
      busy <= 1'b0;
      cnt <= '0;
      err_flag <= 1'b0;
      rr_ptr <= '0;
      ack_prev <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel <= sel_n;
      ack <= ack_n;
      err <= err_n;
      eng_start <= start_n;
      eng_rows <= rows_n;
      eng_cols <= cols_n;
      busy <= busy_n;
      cnt <= cnt_n;
      err_flag <= errf_n;
      rr_ptr <= rr_n;
      ack_prev <= ack;
    end
  end
endmodule

// File: tb/tb_matrix_add_arbiter.sv
// tb_matrix_add_arbiter: directed scenario bench for matrix_add_arbiter
module tb_matrix_add_arbiter;
  localparam int N = 4;
  localparam int TO = 1023;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [3*N-1:0] req_rows = '0;
  logic [3*N-1:0] req_cols = '0;
  logic [N-1:0] grant, ack, err;
  logic [1:0] sel;
  logic eng_start, busy;
  logic [2:0] eng_rows, eng_cols;
  logic eng_done = 1'b0;
  int checks = 0;
  int errors = 0;
  int done_delay = 0;
  int rel_hold = 0;
  int cyc = 0;
  int rel_cnt = 0;
  int start_cnt = 0;
  always #5 clk = ~clk;
  matrix_add_arbiter #(.NUM_REQ(N), .MAX_DIM(6), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rows(req_rows), .req_cols(req_cols),
    .grant(grant), .sel(sel), .ack(ack), .err(err), .eng_start(eng_start),
    .eng_rows(eng_rows), .eng_cols(eng_cols), .eng_done(eng_done), .busy(busy)
  );
  // engine model: done rises done_delay sampled cycles into a start, drops rel_hold cycles after start falls
  always @(negedge clk) begin
    if (eng_start === 1'b1) begin
      cyc = cyc + 1;
      if (done_delay != 0 && cyc >= done_delay) eng_done = 1'b1;
    end else begin
      cyc = 0;
      if (eng_done) begin
        if (rel_cnt >= rel_hold) begin
          eng_done = 1'b0;
          rel_cnt = 0;
        end else rel_cnt = rel_cnt + 1;
      end
    end
  end
  always @(posedge eng_start) start_cnt++;
  task step();
    @(negedge clk);
  endtask
  task do_reset();
    req = '0;
    done_delay = 0;
    rel_hold = 0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask
  task set_dim(input int k, input logic [2:0] r, input logic [2:0] c);
    req_rows[3*k +: 3] = r;
    req_cols[3*k +: 3] = c;
  endtask
  task wait_ack(output int n);
    n = 0;
    while (ack === '0 && n < 60) begin
      step();
      n++;
    end
  endtask
  task run_high(output int n);
    n = 0;
    while (eng_start === 1'b1 && n < 3000) begin
      n++;
      step();
    end
  endtask
  task test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({grant, sel, ack, err, eng_start, eng_rows, eng_cols, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {grant, sel, ack, err, eng_start, eng_rows, eng_cols, busy});
    end
    rst_n = 1'b1;
    step();
  endtask
  task test_single();
    int n;
    do_reset();
    set_dim(1, 3'd3, 3'd2);
    done_delay = 8;
    rel_hold = 2;
    req = 4'b0010;
    step();
    checks++;
    if (grant !== 4'b0010 || sel !== 2'd1) begin
      errors++;
      $display("FAIL single_grant got grant=%b sel=%0d want 0010/1", grant, sel);
    end
    checks++;
    if (eng_start !== 1'b1 || eng_rows !== 3'd3 || eng_cols !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start got start=%b rows=%0d cols=%0d busy=%b want 1/3/2/1", eng_start, eng_rows, eng_cols, busy);
    end
    set_dim(1, 3'd5, 3'd5);
    run_high(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL single_run_len got %0d want 8", n);
    end
    wait_ack(n);
    checks++;
    if (n !== 3 || ack !== 4'b0010 || err !== 4'b0000 || eng_rows !== 3'd3 || eng_cols !== 3'd2) begin
      errors++;
      $display("FAIL single_ack got wait=%0d ack=%b err=%b rows=%0d cols=%0d want 3/0010/0000/3/2", n, ack, err, eng_rows, eng_cols);
    end
    step();
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0 || grant !== 4'b0 || sel !== 2'd1) begin
      errors++;
      $display("FAIL single_idle got ack=%b busy=%b grant=%b sel=%0d want 0000/0/0000/1", ack, busy, grant, sel);
    end
    step();
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_mask got grant=%b busy=%b want 0000/0", grant, busy);
    end
    req = '0;
    step();
  endtask
  task test_round_robin();
    int n;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] want;
    do_reset();
    for (int k = 0; k < N; k++) set_dim(k, 3'd2, 3'd2);
    done_delay = 2;
    req = 4'hF;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      while (grant === '0 && n < 60) begin
        step();
        n++;
      end
      want = 4'b0001 << order[t];
      checks++;
      if (grant !== want) begin
        errors++;
        $display("FAIL rr_grant_%0d got %b want %b", t, grant, want);
      end
      wait_ack(n);
      n = 0;
      while (grant !== '0 && n < 60) begin
        step();
        n++;
      end
    end
    req = '0;
    step();
  endtask
  task test_illegal();
    int s0;
    do_reset();
    set_dim(2, 3'd7, 3'd2);
    set_dim(3, 3'd0, 3'd3);
    s0 = start_cnt;
    req = 4'b1100;
    step();
    checks++;
    if (grant !== 4'b0100 || ack !== 4'b0100 || err !== 4'b0100 || eng_rows !== 3'd7 || eng_cols !== 3'd2 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rows7 got g=%b a=%b e=%b r=%0d c=%0d s=%b want 0100/0100/0100/7/2/0", grant, ack, err, eng_rows, eng_cols, eng_start);
    end
    step();
    checks++;
    if (grant !== 4'b0 || ack !== 4'b0 || err !== 4'b0) begin
      errors++;
      $display("FAIL illegal_gap got g=%b a=%b e=%b want all 0", grant, ack, err);
    end
    req = 4'b1000;
    step();
    checks++;
    if (grant !== 4'b1000 || ack !== 4'b1000 || err !== 4'b1000 || eng_rows !== 3'd0 || eng_cols !== 3'd3 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rows0 got g=%b a=%b e=%b r=%0d c=%0d s=%b want 1000/1000/1000/0/3/0", grant, ack, err, eng_rows, eng_cols, eng_start);
    end
    step();
    req = '0;
    step();
    checks++;
    if (start_cnt !== s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_no_start got starts=%0d busy=%b want %0d/0", start_cnt - s0, busy, 0);
    end
  endtask
  task test_timeout();
    int n;
    do_reset();
    set_dim(1, 3'd1, 3'd1);
    req = 4'b0010;
    step();
    run_high(n);
    checks++;
    if (n !== TO + 1) begin
      errors++;
      $display("FAIL timeout_len got %0d want %0d", n, TO + 1);
    end
    wait_ack(n);
    checks++;
    if (n !== 1 || ack !== 4'b0010 || err !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_ack got wait=%0d ack=%b err=%b want 1/0010/0010", n, ack, err);
    end
    step();
    set_dim(2, 3'd4, 3'd4);
    done_delay = 3;
    req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || eng_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next_grant got g=%b s=%b busy=%b want 0100/1/1", grant, eng_start, busy);
    end
    wait_ack(n);
    checks++;
    if (ack !== 4'b0100 || err !== 4'b0) begin
      errors++;
      $display("FAIL timeout_next_ack got ack=%b err=%b want 0100/0000", ack, err);
    end
    step();
    req = '0;
    step();
  endtask
  task test_collision();
    int n;
    do_reset();
    set_dim(0, 3'd6, 3'd6);
    done_delay = TO + 1;
    req = 4'b0001;
    step();
    checks++;
    if (grant !== 4'b0001 || eng_start !== 1'b1 || eng_rows !== 3'd6 || eng_cols !== 3'd6) begin
      errors++;
      $display("FAIL collide_grant got g=%b s=%b r=%0d c=%0d want 0001/1/6/6", grant, eng_start, eng_rows, eng_cols);
    end
    run_high(n);
    checks++;
    if (n !== TO + 1) begin
      errors++;
      $display("FAIL collide_len got %0d want %0d", n, TO + 1);
    end
    wait_ack(n);
    checks++;
    if (ack !== 4'b0001 || err !== 4'b0) begin
      errors++;
      $display("FAIL collide_ack got ack=%b err=%b want 0001/0000", ack, err);
    end
    step();
    req = '0;
    step();
  endtask
  task test_reset_mid_run();
    int n;
    do_reset();
    set_dim(0, 3'd1, 3'd1);
    set_dim(2, 3'd2, 3'd2);
    set_dim(3, 3'd3, 3'd3);
    req = 4'b0100;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, sel, ack, err, eng_start, eng_rows, eng_cols, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0", {grant, sel, ack, err, eng_start, eng_rows, eng_cols, busy});
    end
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    done_delay = 3;
    req = 4'b1001;
    step();
    checks++;
    if (grant !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_rr_first got grant=%b sel=%0d want 0001/0", grant, sel);
    end
    wait_ack(n);
    step();
    req = 4'b1000;
    step();
    checks++;
    if (grant !== 4'b1000 || sel !== 2'd3 || eng_rows !== 3'd3) begin
      errors++;
      $display("FAIL reset_rr_second got grant=%b sel=%0d rows=%0d want 1000/3/3", grant, sel, eng_rows);
    end
    wait_ack(n);
    step();
    req = '0;
    step();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_illegal();
    test_timeout();
    test_collision();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
